// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single register-file write port (A3/WD3/WE3) between the
//   pipeline writeback stage and the long-latency MDU result path.
//   MDU results wait in a small FIFO. A 32-entry pending scoreboard records
//   the destinations of in-flight long ops so that issue can be stalled.
//   A starvation counter forces a one-cycle writeback stall when the FIFO
//   head has been blocked by writeback for too long.
//
// Ports
//   CLK, RESET               clock (posedge), asynchronous active-low reset
//   wb_valid/addr/data       writeback stage result
//   mdu_valid/addr/data      MDU result offer; mdu_ready = FIFO not full
//   issue_valid/issue_addr   long op issued; mark destination pending
//   q_addr1/2, q_busy1/2     combinational scoreboard queries
//   wb_stall                 registered one-cycle writeback hold
//   rf_a3/rf_wd3/rf_we3      register file write port
//   waw_err                  sticky: writeback hit a pending register
module rf_write_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    input  logic [4:0]  q_addr1,
    input  logic [4:0]  q_addr2,
    output logic        q_busy1,
    output logic        q_busy2,
    output logic        wb_stall,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd3,
    output logic        rf_we3,
    output logic        waw_err
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;
    logic [31:0]   pending;
    logic [31:0]   pending_nxt;

    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        wb_grant;
    logic [4:0]  head_addr;
    logic [31:0] head_data;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign mdu_ready = !full;
    assign push      = mdu_valid && !full;
    assign head_addr = fifo_addr[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    // Gating with RESET keeps a live wb_valid from reaching the RF while
    // reset is held.
    assign wb_grant  = RESET && wb_valid && !wb_stall && (wb_addr != '0);
    assign pop       = !wb_grant && !empty;

    assign q_busy1 = pending[q_addr1] && (q_addr1 != '0);
    assign q_busy2 = pending[q_addr2] && (q_addr2 != '0);

    // Write port mux: writeback first, then FIFO head; an address-0 head
    // is still popped but never writes.
    always_comb begin
        rf_a3  = '0;
        rf_wd3 = '0;
        rf_we3 = 1'b0;
        if (wb_grant) begin
            rf_a3  = wb_addr;
            rf_wd3 = wb_data;
            rf_we3 = 1'b1;
        end else if (!empty) begin
            rf_a3  = head_addr;
            rf_wd3 = head_data;
            rf_we3 = (head_addr != '0);
        end
    end

    // FIFO storage needs no reset; validity comes from count.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_addr[wr_ptr] <= mdu_addr;
            fifo_data[wr_ptr] <= mdu_data;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Clear on pop is applied before set on issue so that a same-cycle
    // set on the popped address survives.
    always_comb begin
        pending_nxt = pending;
        if (pop) pending_nxt[head_addr] = 1'b0;
        if (issue_valid && (issue_addr != '0)) pending_nxt[issue_addr] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pending <= '0;
            waw_err <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (wb_grant && pending[wb_addr]) waw_err <= 1'b1;
        end
    end

    // The counter only advances while the head is blocked by writeback.
    // A stall cycle always pops the head, so the counter restarts and the
    // stall cannot repeat back to back.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            starve_cnt <= '0;
            wb_stall   <= 1'b0;
        end else begin
            wb_stall <= 1'b0;
            if (empty || pop) begin
                starve_cnt <= '0;
            end else if (wb_grant) begin
                if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
                    starve_cnt <= '0;
                    wb_stall   <= 1'b1;
                end else begin
                    starve_cnt <= starve_cnt + SW'(1);
                end
            end
        end
    end

endmodule
